// File: rtl/exp_sequencer_if.sv
// Redirect handshake between the exception sequencer and the PC unit.
// The sequencer is the master: it offers the target PC and the PC unit answers with ready.
interface exp_sequencer_if;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        pc_ready;

  modport master (output pc_redirect, output redirect_pc, input pc_ready);
  modport slave  (input pc_redirect, input redirect_pc, output pc_ready);
endinterface

// File: rtl/exp_sequencer.sv
// Exception/ERET sequencer: holds the pipeline, drains the buses, flushes,
// then hands the target PC to the PC unit. Also synchronizes the interrupt lines.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | pipeline running, waiting for a detector event
// S_DRAIN    | stalled, waiting for instruction/data buses to go idle
// S_FLUSH    | stalled, pipeline registers cleared for FLUSH_CYCLES cycles
// S_REDIRECT | stalled, redirect offered to the PC unit until it is ready
module exp_sequencer #(
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exp_flush,
  input  logic [31:0]           exp_new_pc,
  input  logic                  exp_is_eret,
  input  logic                  mem_busy,
  input  logic                  if_busy,
  input  logic [5:0]            hw_int_async,
  output logic [5:0]            hardware_int,
  output logic                  pipe_stall,
  output logic                  pipe_flush,
  output logic                  cp0_commit,
  output logic                  commit_is_eret,
  output logic                  bus_timeout,
  output logic [15:0]           exp_count,
  exp_sequencer_if.master       rd
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_FLUSH    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  localparam logic [7:0] DRAIN_TC   = 8'(DRAIN_TIMEOUT);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic [7:0]  drain_next;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        is_eret_q, is_eret_d;
  logic        commit_q, commit_d;
  logic        timeout_q, timeout_d;
  logic [15:0] count_q, count_d;
  logic [5:0]  sync1_q, sync1_d;
  logic [5:0]  sync2_q, sync2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      drain_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      redirect_pc_q <= '0;
      is_eret_q     <= 1'b0;
      commit_q      <= 1'b0;
      timeout_q     <= 1'b0;
      count_q       <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_pc_q <= redirect_pc_d;
      is_eret_q     <= is_eret_d;
      commit_q      <= commit_d;
      timeout_q     <= timeout_d;
      count_q       <= count_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_pc_d = redirect_pc_q;
    is_eret_d     = is_eret_q;
    commit_d      = 1'b0;
    timeout_d     = 1'b0;
    count_d       = count_q;
    drain_next    = drain_cnt_q + 8'd1;
    sync1_d       = hw_int_async;
    sync2_d       = sync1_q;

    unique case (state_q)
      S_IDLE: begin
        if (exp_flush) begin
          redirect_pc_d = exp_new_pc;
          is_eret_d     = exp_is_eret;
          commit_d      = 1'b1;
          count_d       = count_q + 16'd1;
          drain_cnt_d   = '0;
          state_d       = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!mem_busy && !if_busy) begin
          flush_cnt_d = FLUSH_LOAD;
          state_d     = S_FLUSH;
        end else begin
          drain_cnt_d = drain_next;
          // A bus that never idles must not hang the core; flush anyway.
          if (drain_next == DRAIN_TC) begin
            timeout_d   = 1'b1;
            flush_cnt_d = FLUSH_LOAD;
            state_d     = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = S_REDIRECT;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      S_REDIRECT: begin
        if (rd.pc_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pipe_stall     = (state_q != S_IDLE);
  assign pipe_flush     = (state_q == S_FLUSH);
  assign rd.pc_redirect = (state_q == S_REDIRECT);
  assign rd.redirect_pc = redirect_pc_q;
  assign cp0_commit     = commit_q;
  assign commit_is_eret = is_eret_q;
  assign bus_timeout    = timeout_q;
  assign exp_count      = count_q;
  assign hardware_int   = sync2_q;

endmodule

// File: doc/exp_sequencer.md
# exp_sequencer

Sequences the pipeline response to a precise exception or ERET reported by the combinational exception detector in the MM stage. It holds the pipeline, drains outstanding instruction and data bus transactions, asserts a multi-cycle flush, and then hands the exception target PC to the PC unit with a valid/ready handshake. It also synchronizes the asynchronous hardware interrupt lines before they reach the detector, and issues the single CP0 commit strobe per event.

## Interface
- FLUSH_CYCLES, 2: number of cycles `pipe_flush` is held high; legal range 1..15.
- DRAIN_TIMEOUT, 255: maximum number of DRAIN cycles before a forced exit; legal range 1..255.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- exp_flush  input  1  detector requests an exception or ERET redirect this cycle.
- exp_new_pc  input  32  target PC from the detector; valid when `exp_flush`=1.
- exp_is_eret  input  1  the event is an ERET (detector `cp0_clean_exl`).
- mem_busy  input  1  a data-bus transaction is outstanding.
- if_busy  input  1  an instruction-fetch transaction is outstanding.
- pc_ready  input  1  PC unit accepts the redirect this cycle.
- hw_int_async  input  6  raw external interrupt lines, asynchronous to clk.
- hardware_int  output  6  interrupt lines after 2-flop synchronization, sent to the detector.
- pipe_stall  output  1  freezes all pipeline registers.
- pipe_flush  output  1  clears IF/ID/EX/MM pipeline registers to bubbles.
- pc_redirect  output  1  redirect valid toward the PC unit.
- redirect_pc  output  32  latched target PC.
- cp0_commit  output  1  one-cycle strobe telling CP0 to write EPC/Cause/BadVAddr, or to clear EXL on ERET.
- commit_is_eret  output  1  latched `exp_is_eret`; valid while `cp0_commit`=1.
- bus_timeout  output  1  one-cycle pulse when DRAIN exits because of the timeout.
- exp_count  output  16  number of accepted events; wraps at 0xFFFF->0.

## Operation
- FSM states are IDLE, DRAIN, FLUSH and REDIRECT. All outputs are registered or are a decode of the registered state.
- **IDLE:**
  - `pipe_stall`=0.
  - When `exp_flush`=1 at an edge, latch `exp_new_pc` into `redirect_pc` and `exp_is_eret` into `commit_is_eret`.
  - On that same edge, set `cp0_commit`=1 for the next cycle only, increment `exp_count`, clear the drain counter, and go to DRAIN.
- **DRAIN:**
  - `pipe_stall`=1.
  - At each edge, if `mem_busy`=0 and `if_busy`=0, go to FLUSH and load the flush counter with FLUSH_CYCLES-1.
  - Otherwise increment the drain counter. When it reaches DRAIN_TIMEOUT, pulse `bus_timeout` for one cycle and go to FLUSH anyway.
- **FLUSH:**
  - `pipe_stall`=1 and `pipe_flush`=1.
  - The counter decrements each edge. When the counter is 0 at an edge, go to REDIRECT.
- **REDIRECT:**
  - `pipe_stall`=1 and `pc_redirect`=1.
  - `redirect_pc` stays stable until `pc_ready`=1 is sampled, then go to IDLE.
- `exp_flush` is ignored outside IDLE. Nested events are not queued. The detector re-raises an event after restart if it still applies.
- Interrupt synchronizer:
  - Two flops per bit, free-running in all states.
  - `hardware_int` = second flop.
- Reset (async, `rst_n`=0):
  - State goes to IDLE and all counters clear.
  - `pipe_stall`, `pipe_flush`, `pc_redirect`, `cp0_commit`, `commit_is_eret` and `bus_timeout` are 0.
  - `redirect_pc`=0, `exp_count`=0, and both synchronizer stages are 0.
  - Reset mid-sequence abandons the event with no commit or redirect.

## Timing
- `exp_flush` sampled at edge E0 gives the following sequence with an idle bus:
  - Cycle 1: DRAIN, `cp0_commit`=1.
  - Cycles 2..FLUSH_CYCLES+1: FLUSH.
  - Cycle FLUSH_CYCLES+2: REDIRECT.
  - With default parameters, the earliest redirect is cycle 4.
- Each busy DRAIN edge adds one cycle. A timeout exit happens after exactly DRAIN_TIMEOUT busy DRAIN cycles; `bus_timeout` is high in the first FLUSH cycle.
- In REDIRECT, if `pc_ready`=1 in cycle N, then cycle N+1 is IDLE with `pipe_stall`=0. A new `exp_flush` can be accepted at the end of cycle N+1.
- `cp0_commit` is exactly one cycle per accepted event, and is never asserted while `pc_redirect`=1.
- `hardware_int` latency from a stable input is 2 edges.

## Test plan
- Reset release, then `hw_int_async`=6'b000100: `hardware_int`=6'b000100 after exactly 2 edges; every other output keeps its reset value.
- `exp_flush`=1, `exp_new_pc`=0xBFC00380, bus idle, `pc_ready`=1: `cp0_commit` in cycle 1, `pipe_flush` in cycles 2–3, `pc_redirect` with 0x BFC00380 in cycle 4, IDLE in cycle 5, `exp_count`=1.
- ERET with `exp_new_pc`=0x80001234 and `mem_busy` held for 5 cycles: `commit_is_eret`=1; DRAIN lasts 6 cycles; `redirect_pc`=0x80001234.
- DRAIN_TIMEOUT=4 with `mem_busy` stuck at 1: after 4 DRAIN cycles, `bus_timeout` pulses once and FLUSH proceeds.
- `pc_ready` low for 3 REDIRECT cycles while `exp_flush` toggles: `redirect_pc` stays stable, no second commit occurs, and `exp_count` increments only once.
- `rst_n` asserted during FLUSH: all outputs clear immediately (asynchronously); no `pc_redirect` appears after release.
